// File: rtl/apu_frame_pkg.sv
// Shared constants and types for the APU frame sequencer.
package apu_frame_pkg;

  // Cycle counter width; it must hold the 5-step terminal count 18640.
  localparam int CNT_W = 15;

  // APU-cycle counts at which the sequencer emits events.
  localparam logic [CNT_W-1:0] STEP1 = 15'd3728;
  localparam logic [CNT_W-1:0] STEP2 = 15'd7456;
  localparam logic [CNT_W-1:0] STEP3 = 15'd11185;
  localparam logic [CNT_W-1:0] STEP4 = 15'd14914;
  localparam logic [CNT_W-1:0] STEP5 = 15'd18640;

  // Decode result for one counter value. irq_set is raw and still has to be
  // gated by the IRQ inhibit bit.
  typedef struct packed {
    logic qf;
    logic hf;
    logic irq_set;
  } frame_evt_t;

endpackage

// File: rtl/apu_frame_decode.sv
// Combinational step decoder: maps (cnt, mode) to frame events and the wrap flag.
module apu_frame_decode
  import apu_frame_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             mode_i,
  output frame_evt_t       evt_o,
  output logic             wrap_o
);

  // Match the current count against the step table for the active mode.
  always_comb begin
    evt_o  = '0;
    wrap_o = 1'b0;
    if (cnt_i == STEP1 || cnt_i == STEP3) begin
      evt_o.qf = 1'b1;
    end
    if (cnt_i == STEP2) begin
      evt_o.qf = 1'b1;
      evt_o.hf = 1'b1;
    end
    // Step 4 is the last step of 4-step mode; in 5-step mode it is silent.
    if (!mode_i && cnt_i == STEP4) begin
      evt_o.qf      = 1'b1;
      evt_o.hf      = 1'b1;
      evt_o.irq_set = 1'b1;
      wrap_o        = 1'b1;
    end
    if (mode_i && cnt_i == STEP5) begin
      evt_o.qf = 1'b1;
      evt_o.hf = 1'b1;
      wrap_o   = 1'b1;
    end
  end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts APU-cycle ticks in 4- or 5-step mode, emits
// quarter/half-frame strobes and raises the frame IRQ, programmed via $4017.
module apu_frame_counter
  import apu_frame_pkg::*;
(
  input  logic       CLK,
  input  logic       RES,
  input  logic       ACLK_en,
  input  logic       W4017,
  input  logic [7:0] DIN,
  input  logic       R4015,
  output logic       QF,
  output logic       HF,
  output logic       FRAME_IRQ,
  output logic       MODE
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             irq_q, irq_d;
  logic             pend_q, pend_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;

  frame_evt_t       evt;
  logic             wrap;

  apu_frame_decode u_decode (
    .cnt_i  (cnt_q),
    .mode_i (mode_q),
    .evt_o  (evt),
    .wrap_o (wrap)
  );

  // Next-state logic; the order of the IRQ updates encodes its priority:
  // ack < set < inhibit-write clear.
  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    pend_d    = pend_q;
    qf_d      = 1'b0;
    hf_d      = 1'b0;

    if (R4015) begin
      irq_d = 1'b0;
    end

    if (ACLK_en) begin
      if (pend_q) begin
        // Deferred sequencer reset from an earlier write; decode is skipped
        // and 5-step mode clocks the units immediately.
        cnt_d  = '0;
        pend_d = 1'b0;
        qf_d   = mode_q;
        hf_d   = mode_q;
      end else begin
        qf_d = evt.qf;
        hf_d = evt.hf;
        // Only an exact match wraps, so an out-of-range count after a mode
        // switch simply rolls over modulo 2^CNT_W.
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (evt.irq_set && !inhibit_q) begin
          irq_d = 1'b1;
        end
      end
    end

    // A write lands after the tick logic: the tick used the old state and the
    // new pending reset waits for the next tick.
    if (W4017) begin
      mode_d    = DIN[7];
      inhibit_d = DIN[6];
      pend_d    = 1'b1;
      if (DIN[6]) begin
        irq_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset that dominates every input.
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      pend_q    <= 1'b0;
      qf_q      <= 1'b0;
      hf_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
      pend_q    <= pend_d;
      qf_q      <= qf_d;
      hf_q      <= hf_d;
    end
  end

  assign QF        = qf_q;
  assign HF        = hf_q;
  assign FRAME_IRQ = irq_q;
  assign MODE      = mode_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Self-checking bench for apu_frame_counter against a tick-level reference model.
module tb_apu_frame_counter;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       aclk = 1'b0;
  logic       w4017 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       r4015 = 1'b0;
  logic       qf, hf, irq, mode;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position within the frame sequence plus register bits.
  int m_pos = 0;
  bit m_mode = 0, m_inh = 0, m_irq = 0, m_pend = 0, m_qf = 0, m_hf = 0;

  // Strobe logging by tick index, used for the sequence-level checks.
  bit rec_en = 0;
  int tick_no = 0;
  int qf_log[$];
  int hf_log[$];

  apu_frame_counter dut (
    .CLK       (clk),
    .RES       (res),
    .ACLK_en   (aclk),
    .W4017     (w4017),
    .DIN       (din),
    .R4015     (r4015),
    .QF        (qf),
    .HF        (hf),
    .FRAME_IRQ (irq),
    .MODE      (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the behavioural model, straight from the frame rules.
  task automatic model_step(input bit i_res, input bit i_ak, input bit i_w,
                            input logic [7:0] i_d, input bit i_r);
    bit set_irq;
    int last;
    set_irq = 0;
    if (i_res) begin
      m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_pend = 0; m_qf = 0; m_hf = 0;
      return;
    end
    m_qf = 0;
    m_hf = 0;
    if (i_ak) begin
      if (m_pend) begin
        m_pos  = 0;
        m_pend = 0;
        m_qf   = m_mode;
        m_hf   = m_mode;
      end else begin
        last = m_mode ? 18640 : 14914;
        if (m_pos == 3728 || m_pos == 7456 || m_pos == 11185) m_qf = 1;
        if (m_pos == 7456) m_hf = 1;
        if (m_pos == last) begin
          m_qf = 1;
          m_hf = 1;
          set_irq = !m_mode && !m_inh;
        end
        m_pos = (m_pos == last) ? 0 : (m_pos + 1) % 32768;
      end
    end
    if (i_r) m_irq = 0;
    if (set_irq) m_irq = 1;
    if (i_w) begin
      m_mode = i_d[7];
      m_inh  = i_d[6];
      m_pend = 1;
      if (i_d[6]) m_irq = 0;
    end
  endtask

  // Drive one clock cycle, advance the model and compare all outputs.
  task automatic cyc(input bit i_res, input bit i_ak, input bit i_w,
                     input logic [7:0] i_d, input bit i_r);
    res = i_res; aclk = i_ak; w4017 = i_w; din = i_d; r4015 = i_r;
    if (i_res) $display("[%0t] reset", $time);
    if (i_w)   $display("[%0t] write $4017 = %02h (tick=%0d)", $time, i_d, i_ak);
    if (i_r)   $display("[%0t] read $4015 (tick=%0d)", $time, i_ak);
    @(posedge clk);
    model_step(i_res, i_ak, i_w, i_d, i_r);
    if (i_res) tick_no = 0;
    else if (i_ak) tick_no++;
    @(negedge clk);
    res = 0; aclk = 0; w4017 = 0; din = 8'h00; r4015 = 0;
    chk("QF", qf, m_qf);
    chk("HF", hf, m_hf);
    chk("FRAME_IRQ", irq, m_irq);
    chk("MODE", mode, m_mode);
    if (rec_en && i_ak && !i_res) begin
      if (qf) qf_log.push_back(tick_no - 1);
      if (hf) hf_log.push_back(tick_no - 1);
    end
  endtask

  task automatic run_ticks(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      repeat (spacing - 1) cyc(0, 0, 0, 8'h00, 0);
      cyc(0, 1, 0, 8'h00, 0);
    end
  endtask

  // Tick until the model says the next tick will decode position pos.
  task automatic run_to(input int pos, input int spacing);
    bit hit;
    hit = 0;
    for (int k = 0; k < 40000; k++) begin
      if (m_pos == pos && !m_pend) begin
        hit = 1;
        break;
      end
      run_ticks(1, spacing);
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_to: position %0d not reached, model at %0d", pos, m_pos);
    end
  endtask

  task automatic chk_log(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  initial begin
    int exp_q[$];
    @(negedge clk);

    // Reset state.
    repeat (3) cyc(1, 0, 0, 8'h00, 0);
    chk("rst_qf", qf, 0);
    chk("rst_hf", hf, 0);
    chk("rst_irq", irq, 0);
    chk("rst_mode", mode, 0);

    // 4-step mode, first part with a tick every 2 CLK.
    rec_en = 1;
    qf_log.delete(); hf_log.delete();
    run_ticks(3729, 2);
    run_to(14914, 1);
    cyc(0, 1, 0, 8'h00, 1);            // IRQ set and ack on the same edge
    chk("irq_set_beats_ack", irq, 1);
    run_ticks(3, 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("irq_ack", irq, 0);
    run_to(14914, 1);
    cyc(0, 1, 0, 8'h00, 0);
    chk("irq_lap2", irq, 1);
    rec_en = 0;
    exp_q = '{3728, 7456, 11185, 14914, 18643, 22371, 26100, 29829};
    chk_log("qf4", qf_log, exp_q);
    exp_q = '{7456, 14914, 22371, 29829};
    chk_log("hf4", hf_log, exp_q);

    // Inhibit write clears a pending IRQ and blocks the next set.
    cyc(0, 0, 1, 8'h40, 0);
    chk("inh_clear", irq, 0);
    cyc(0, 1, 0, 8'h00, 0);
    chk("inh_reset_noqf", qf, 0);
    run_to(14914, 1);
    cyc(0, 1, 0, 8'h00, 0);
    chk("inh_step4_qf", qf, 1);
    chk("inh_no_set", irq, 0);

    // 5-step mode.
    cyc(0, 0, 1, 8'hC0, 0);
    chk("mode5", mode, 1);
    cyc(0, 1, 0, 8'h00, 0);
    chk("mode5_rst_qf", qf, 1);
    chk("mode5_rst_hf", hf, 1);
    run_to(100, 1);
    cyc(0, 1, 1, 8'hC0, 0);            // write coinciding with a tick
    chk("wr_tick_noqf", qf, 0);
    cyc(0, 1, 0, 8'h00, 0);            // pending reset serviced here
    chk("wr_tick_rst_qf", qf, 1);
    chk("wr_tick_rst_hf", hf, 1);
    tick_no = 0;
    qf_log.delete(); hf_log.delete();
    rec_en = 1;
    run_to(18640, 1);
    cyc(0, 1, 0, 8'h00, 0);
    run_to(3728, 1);
    cyc(0, 1, 0, 8'h00, 0);
    rec_en = 0;
    exp_q = '{3728, 7456, 11185, 18640, 22369};
    chk_log("qf5", qf_log, exp_q);
    exp_q = '{7456, 18640};
    chk_log("hf5", hf_log, exp_q);
    chk("mode5_no_irq", irq, 0);

    // Reset in the middle of a 5-step sequence, on the step-2 tick.
    run_to(7456, 1);
    cyc(1, 1, 0, 8'h00, 0);
    chk("midrst_qf", qf, 0);
    chk("midrst_hf", hf, 0);
    chk("midrst_mode", mode, 0);
    run_ticks(200, 1);

    // Randomised tail: sparse writes, acks, resets and irregular tick spacing.
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom % 1200) == 0,
          ($urandom_range(0, 2) == 0),
          ($urandom % 150) == 0,
          8'($urandom),
          ($urandom % 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apu_frame_counter.md
# apu_frame_counter

APU frame sequencer driven by the APU-cycle strobe from the clock generator. It counts APU cycles in 4-step or 5-step mode and emits single-cycle quarter-frame and half-frame strobes to the envelope, linear, length and sweep units. In 4-step mode with IRQ enabled it raises the frame interrupt. It sits directly downstream of the clock generator and is programmed by CPU writes to $4017.

## Interface
- CNT_W, 15: cycle counter width; must hold 18640.
- CLK  in  1  master clock. One clock; all state changes on posedge CLK.
- RES  in  1  reset, synchronous, active-high.
- ACLK_en  in  1  APU-cycle tick, one CLK wide, from the clock generator. In the system it pulses once per 24 CLK; the block must work for any spacing of 1 or more cycles.
- W4017  in  1  register write strobe, one CLK wide.
- DIN  in  8  write data; only bits 7 (MODE) and 6 (IRQ inhibit) are used.
- R4015  in  1  status read strobe, one CLK wide; acknowledges the frame IRQ.
- QF  out  1  quarter-frame strobe, one CLK wide.
- HF  out  1  half-frame strobe, one CLK wide.
- FRAME_IRQ  out  1  frame interrupt flag, level.
- MODE  out  1  current mode: 0 = 4-step, 1 = 5-step.

## Operation
- State:
  - cnt[CNT_W-1:0]
  - MODE
  - INHIBIT
  - FRAME_IRQ
  - pend: reset request pending
  - QF and HF registers
- Reset: every state bit and every output is 0.
- Decode runs on a tick (ACLK_en=1, pend=0) against the current value of cnt:
  - 3728 -> QF
  - 7456 -> QF and HF
  - 11185 -> QF
  - 14914 with MODE=0 -> QF and HF, and FRAME_IRQ is set if INHIBIT=0
  - 14914 with MODE=1 -> no event
  - 18640 with MODE=1 -> QF and HF
- Count on a tick with pend=0: cnt wraps to 0 when it equals LAST, otherwise cnt+1.
  - LAST = 14914 in 4-step mode (period 14915 ticks).
  - LAST = 18640 in 5-step mode (period 18641 ticks).
- Counter outside the range after a mode change (cnt > LAST): it keeps incrementing modulo 2^CNT_W. This is unreachable in practice because every write forces a reset.
- W4017, taking effect on the same edge:
  - MODE <= DIN[7]
  - INHIBIT <= DIN[6]
  - pend <= 1
  - if DIN[6]=1, FRAME_IRQ <= 0
- First tick with pend=1:
  - cnt <= 0 and pend <= 0
  - the normal decode is suppressed
  - if MODE=1, QF and HF pulse on this tick
- W4017 coinciding with a tick: the tick runs with the old state. The new pend is serviced on the following tick.
- Another W4017 while pend=1: the latest data wins and only one reset occurs.
- R4015 clears FRAME_IRQ.
- FRAME_IRQ priority in a single cycle:
  - set and R4015 together -> set wins
  - set and W4017 with DIN[6]=1 together -> clear wins
- QF and HF deassert on every CLK edge that is not an emitting tick.

## Timing
- Strobe latency: QF, HF and the FRAME_IRQ rise are registered on the same CLK edge that samples ACLK_en=1. They are visible in the following CLK cycle and last exactly one CLK.
- Write latency: MODE and the IRQ clear are visible 1 CLK after W4017. The counter reset lands on the next ACLK_en edge, that is 1 to 24 CLK later in the system.
- FRAME_IRQ holds until R4015, a W4017 with DIN[6]=1, or RES.
- RES dominates every other input in the same cycle.
- RES in the middle of a sequence returns the block to 4-step mode with cnt=0 on the next edge.

## Structure
- Package apu_frame_pkg holds:
  - CNT_W
  - step constants STEP1=3728, STEP2=7456, STEP3=11185, STEP4=14914, STEP5=18640
  - a packed struct for the decode result {qf, hf, irq_set}
- Sub-module apu_frame_decode, combinational: takes (cnt, MODE) and returns the decode struct and the wrap flag. The top module keeps all registers.

## Test plan
- 4-step mode after RES, ACLK_en every 2 CLK:
  - QF at ticks 3728, 7456, 11185 and 14914
  - HF at ticks 7456 and 14914 only
  - FRAME_IRQ=1 after tick 14914
  - next QF at tick 14915+3728
- 5-step mode, write DIN=0xC0:
  - MODE=1 one cycle later
  - QF and HF together on the next tick
  - QF at 3728, 7456, 11185 and 18640; HF at 7456 and 18640; none at 14914
  - FRAME_IRQ stays 0; period is 18641
- IRQ ack and inhibit:
  - with FRAME_IRQ=1, R4015 -> 0 on the next cycle
  - R4015 on the setting cycle -> FRAME_IRQ=1
  - W4017 with DIN=0x40 while FRAME_IRQ=1 -> 0, and no set at the next 14914
- Write on a tick edge: W4017 at cnt=100 coinciding with ACLK_en -> cnt=101, then the following tick gives cnt=0 with no decode.
- Reset mid-run: RES pulse at cnt=7456 in 5-step mode -> all outputs 0, MODE=0, cnt=0 on the next edge; the sequence restarts in 4-step mode.
